// File: rtl/fun_g_seq.sv
// fun_g_seq: applies g(u) = u*exp(-u*u/2) to every element of a matrix, streaming the
// elements through one shared fixed-latency exp core and writing results back in issue order.

package fp_double;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  // IEEE-754 binary64 multiply, round-to-nearest-even, subnormals handled on both sides.
  function automatic logic [63:0] mul_double(input logic [63:0] a, input logic [63:0] b);
    logic         sign;
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [52:0]  ma, mb;
    logic [105:0] prod, lost;
    logic [10:0]  ex_field;
    logic [62:0]  body;
    logic         rnd;
    int           ex_a, ex_b, ex, sh;
    sign   = a[63] ^ b[63];
    a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != '0);
    b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != '0);
    a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == '0);
    b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == '0);
    a_zero = (a[62:0] == '0);
    b_zero = (b[62:0] == '0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return QNAN;
    if (a_inf || b_inf) return {sign, 11'h7FF, 52'd0};
    if (a_zero || b_zero) return {sign, 63'd0};
    ma   = {(a[62:52] != 11'd0), a[51:0]};
    mb   = {(b[62:52] != 11'd0), b[51:0]};
    ex_a = (a[62:52] == 11'd0) ? 1 : int'(a[62:52]);
    ex_b = (b[62:52] == 11'd0) ? 1 : int'(b[62:52]);
    for (int i = 0; i < 52; i++) begin
      if (!ma[52]) begin
        ma   = ma << 1;
        ex_a = ex_a - 1;
      end
      if (!mb[52]) begin
        mb   = mb << 1;
        ex_b = ex_b - 1;
      end
    end
    prod = {53'd0, ma} * {53'd0, mb};
    ex   = ex_a + ex_b - 1023;
    if (prod[105]) ex = ex + 1;
    else           prod = prod << 1;
    if (ex >= 2047) return {sign, 11'h7FF, 52'd0};
    ex_field = 11'd0;
    if (ex <= 0) begin
      // Subnormal result: denormalise before rounding so the guard/sticky bits stay exact.
      sh = 1 - ex;
      if (sh > 105) begin
        prod = 106'd1;
      end else begin
        lost    = prod & ~({106{1'b1}} << sh);
        prod    = prod >> sh;
        prod[0] = prod[0] | (lost != '0);
      end
    end else begin
      ex_field = ex[10:0];
    end
    body = {ex_field, prod[104:53]};
    rnd  = prod[52] && ((prod[51:0] != '0) || prod[53]);
    return {sign, body + {62'd0, rnd}};
  endfunction
endpackage

// Behavioural model of the exp core: result and flags appear exactly LATENCY edges after data.
module double_exp #(
  parameter int LATENCY = 17
) (
  input  logic        clock,
  input  logic [63:0] data,
  output logic [63:0] result,
  output logic        nan,
  output logic        overflow,
  output logic        underflow,
  output logic        zero
);
  typedef struct packed {
    logic [63:0] res;
    logic        nan;
    logic        ovf;
    logic        unf;
    logic        zro;
  } exp_out_t;

  logic        in_nan, in_fin;
  logic [63:0] res_c;
  exp_out_t    stage_d;
  exp_out_t    pipe_q [LATENCY];

  always_comb begin
    in_nan      = (data[62:52] == 11'h7FF) && (data[51:0] != '0);
    in_fin      = (data[62:52] != 11'h7FF);
    res_c       = in_nan ? fp_double::QNAN : $realtobits($exp($bitstoreal(data)));
    stage_d     = '0;
    stage_d.res = res_c;
    stage_d.nan = in_nan;
    stage_d.ovf = in_fin && (res_c[62:52] == 11'h7FF);
    stage_d.unf = in_fin && (res_c[62:52] == 11'd0);
    stage_d.zro = (res_c[62:0] == '0);
  end

  always_ff @(posedge clock) begin
    pipe_q[0] <= stage_d;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign result    = pipe_q[LATENCY-1].res;
  assign nan       = pipe_q[LATENCY-1].nan;
  assign overflow  = pipe_q[LATENCY-1].ovf;
  assign underflow = pipe_q[LATENCY-1].unf;
  assign zero      = pipe_q[LATENCY-1].zro;
endmodule

// state | meaning
// IDLE  | no run since reset, waiting for start
// ISSUE | feeding one element per cycle into the exp core
// DRAIN | all issued, collecting remaining exp results
// DONE  | mat_out complete and valid, waiting for start
module fun_g_seq #(
  parameter int SIZE_A      = 8,
  parameter int SIZE_B      = 8,
  parameter int EXP_LATENCY = 17
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [SIZE_A-1:0][SIZE_B-1:0][63:0] mat,
  output logic [SIZE_A-1:0][SIZE_B-1:0][63:0] mat_out,
  output logic                               valid,
  output logic                               busy,
  output logic                               err
);
  import fp_double::*;

  localparam int            N        = SIZE_A * SIZE_B;
  localparam int            CW       = $clog2(N + 1);
  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [63:0]   NEG_HALF = 64'hBFE0_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      iss_cnt_q, iss_cnt_d, wr_cnt_q, wr_cnt_d;
  logic               valid_q, valid_d, busy_q, busy_d, err_q, err_d;
  logic               load, issue, wr_en;
  logic [N-1:0][63:0] buf_q, out_q;
  logic [EXP_LATENCY-1:0] tag_q;
  logic [63:0]        u_dl_q [EXP_LATENCY];
  logic [63:0]        u_iss, exp_data, exp_res, g_val;
  logic               exp_nan, exp_ovf, exp_unf, exp_zero;
  logic               unused_flags;

  assign u_iss    = buf_q[iss_cnt_q[IW-1:0]];
  assign exp_data = mul_double(mul_double(u_iss, u_iss), NEG_HALF);

  double_exp #(.LATENCY(EXP_LATENCY)) u_exp (
    .clock     (clk),
    .data      (exp_data),
    .result    (exp_res),
    .nan       (exp_nan),
    .overflow  (exp_ovf),
    .underflow (exp_unf),
    .zero      (exp_zero)
  );

  // Underflow/zero results are legitimate tiny values of g, not errors.
  assign unused_flags = exp_unf ^ exp_zero;

  assign wr_en = tag_q[EXP_LATENCY-1];
  assign g_val = mul_double(u_dl_q[EXP_LATENCY-1], exp_res);

  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    err_d     = err_q;
    load      = 1'b0;
    issue     = 1'b0;
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      err_d    = err_q | exp_nan | exp_ovf;
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_d   = ISSUE;
          valid_d   = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          iss_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      ISSUE: begin
        issue     = 1'b1;
        iss_cnt_d = iss_cnt_q + 1'b1;
        if (iss_cnt_d == N_CNT) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_cnt_q == N_CNT) begin
          state_d = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iss_cnt_q <= '0;
      wr_cnt_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      tag_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      tag_q[0]  <= issue;
      for (int i = 1; i < EXP_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (wr_en) out_q[wr_cnt_q[IW-1:0]] <= g_val;
    end
  end

  // Operand buffer and u delay line carry data only; the tags decide whether it is used.
  always_ff @(posedge clk) begin
    if (load) buf_q <= mat;
    u_dl_q[0] <= u_iss;
    for (int i = 1; i < EXP_LATENCY; i++) u_dl_q[i] <= u_dl_q[i-1];
  end

  assign mat_out = out_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign err     = err_q;
endmodule

// File: tb/tb_fun_g_seq.sv
// Scoreboard bench for fun_g_seq: runs push expected matrices, a monitor checks on each valid rise.
module tb_fun_g_seq;
  localparam int A   = 2;
  localparam int B   = 2;
  localparam int N   = A * B;
  localparam int L   = 17;
  localparam int LAT = N + L + 1;

  typedef struct packed {
    logic [N-1:0][63:0] g;
    logic [N-1:0][63:0] lit;
    logic               use_lit;
    logic               err;
    int                 start_cyc;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [A-1:0][B-1:0][63:0] mat = '0;
  logic [A-1:0][B-1:0][63:0] mat_out;
  logic                     valid, busy, err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  logic [63:0] cur_u   [N];
  logic [63:0] cur_lit [N];

  fun_g_seq #(.SIZE_A(A), .SIZE_B(B), .EXP_LATENCY(L)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mat     (mat),
    .mat_out (mat_out),
    .valid   (valid),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != '0);
  endfunction

  function automatic logic [63:0] g_model(input logic [63:0] u);
    real x;
    x = $bitstoreal(u);
    return $realtobits(x * $exp(-(x * x) / 2.0));
  endfunction

  function automatic bit close(input logic [63:0] a, input logic [63:0] e);
    logic [62:0] d;
    if (is_nan(e)) return is_nan(a);
    if (is_nan(a)) return 1'b0;
    if (a[62:0] == '0 && e[62:0] == '0) return 1'b1;
    if (a[63] != e[63]) return 1'b0;
    d = (a[62:0] > e[62:0]) ? a[62:0] - e[62:0] : e[62:0] - a[62:0];
    return d <= 63'd1;
  endfunction

  function automatic logic [63:0] rand_u();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 64'h7FF8_0000_0000_0001;
    if (r == 1) return 64'd0;
    return $realtobits(real'(int'($urandom_range(0, 20000)) - 10000) / 1250.0);
  endfunction

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_valid"}, valid == 1'b0, 64'(valid), 64'd0);
    chk({tag, "_busy"},  busy == 1'b0,  64'(busy),  64'd0);
    chk({tag, "_err"},   err == 1'b0,   64'(err),   64'd0);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_mat_out[%0d]", tag, k), mat_out[k/B][k%B] == 64'd0, mat_out[k/B][k%B], 64'd0);
  endtask

  // Issues one start pulse with cur_u and records the expected result.
  task automatic launch(input bit use_lit);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++) mat[k/B][k%B] = cur_u[k];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = '0;
    e.start_cyc = cyc;
    e.use_lit   = use_lit;
    for (int k = 0; k < N; k++) begin
      e.g[k]   = g_model(cur_u[k]);
      e.lit[k] = cur_lit[k];
      if (is_nan(cur_u[k])) e.err = 1'b1;
    end
    sb_q.push_back(e);
    chk("valid_low_after_start", valid == 1'b0, 64'(valid), 64'd0);
    chk("busy_after_start", busy == 1'b1, 64'(busy), 64'd1);
    for (int k = 0; k < N; k++) mat[k/B][k%B] = rand_u();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk({name, "_timeout"}, 1'b0, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev;
    real  r;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 1'b0, 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          for (int k = 0; k < N; k++) begin
            chk($sformatf("g[%0d]", k), close(mat_out[k/B][k%B], e.g[k]), mat_out[k/B][k%B], e.g[k]);
            if (e.use_lit) begin
              r = $bitstoreal(mat_out[k/B][k%B]) - $bitstoreal(e.lit[k]);
              if (r < 0.0) r = -r;
              chk($sformatf("lit[%0d]", k), r < 1.0e-9, mat_out[k/B][k%B], e.lit[k]);
            end
          end
          chk("err", err == e.err, 64'(err), 64'(e.err));
          chk("latency", (cyc - e.start_cyc) == LAT, 64'(cyc - e.start_cyc), 64'(LAT));
          chk("busy_at_valid", busy == 1'b0, 64'(busy), 64'd0);
        end
      end
      prev = valid;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int k = 0; k < N; k++) cur_lit[k] = 64'd0;
    repeat (3) @(negedge clk);
    chk_quiet_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) cur_u[k] = 64'd0;
    launch(1'b1);
    wait_done("zeros");

    cur_u[0] = $realtobits(1.0);  cur_u[1] = $realtobits(-1.0);
    cur_u[2] = $realtobits(2.0);  cur_u[3] = $realtobits(-2.0);
    cur_lit[0] = $realtobits(0.6065306597);  cur_lit[1] = $realtobits(-0.6065306597);
    cur_lit[2] = $realtobits(0.2706705664);  cur_lit[3] = $realtobits(-0.2706705664);
    launch(1'b1);
    wait_done("basic");

    for (int k = 0; k < N; k++) cur_u[k] = $realtobits(1.0);
    cur_u[2] = 64'h7FF8_0000_0000_0000;
    launch(1'b0);
    wait_done("nan");

    // Second start mid-run with a different matrix must be ignored.
    cur_u[0] = $realtobits(0.5);  cur_u[1] = $realtobits(-3.0);
    cur_u[2] = $realtobits(1.5);  cur_u[3] = $realtobits(0.25);
    launch(1'b0);
    for (int k = 0; k < N; k++) mat[k/B][k%B] = $realtobits(7.0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", busy == 1'b1, 64'(busy), 64'd1);
    wait_done("ignored_start");

    // Reset mid-run aborts the run; a fresh run afterwards must be clean.
    for (int k = 0; k < N; k++) cur_u[k] = $realtobits(3.0);
    launch(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb_q.delete();
    chk_quiet_outputs("midrun_reset");
    rst_n = 1'b1;
    cur_u[0] = $realtobits(-0.75); cur_u[1] = $realtobits(1.25);
    cur_u[2] = $realtobits(4.0);   cur_u[3] = $realtobits(-0.125);
    launch(1'b0);
    wait_done("after_reset");

    // Back-to-back: start issued while in DONE.
    for (int k = 0; k < N; k++) cur_u[k] = rand_u();
    launch(1'b0);
    wait_done("b2b_first");
    for (int k = 0; k < N; k++) cur_u[k] = rand_u();
    launch(1'b0);
    wait_done("b2b_second");

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++) cur_u[k] = rand_u();
      launch(1'b0);
      if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 8))) @(negedge clk);
      wait_done($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fun_g_seq.md
FUN_G_SEQ -- requirements
Module: fun_g_seq

Interface
REQ-001 SHALL have parameter SIZE_A, default 8, meaning matrix rows.
REQ-002 SHALL have parameter SIZE_B, default 8, meaning matrix columns.
REQ-003 SHALL have parameter EXP_LATENCY, default 17, meaning fixed clock latency of the double_exp core.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to process mat.
REQ-007 SHALL have port mat  input  double[SIZE_A][SIZE_B]  input matrix, sampled only on the accepted start edge.
REQ-008 SHALL have port mat_out  output  double[SIZE_A][SIZE_B]  registered result g(u) = u*exp(-u*u/2) per element.
REQ-009 SHALL have port valid  output  1  high when mat_out holds a complete result.
REQ-010 SHALL have port busy  output  1  high while a run is in progress.
REQ-011 SHALL have port err  output  1  sticky OR of the nan/overflow flags from every exp result of the current run.

Function
REQ-012 SHALL use one shared double_exp instance: ports clock, data, result, nan, overflow, underflow, zero. Arithmetic SHALL use mul_double from fp_double.
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-014 IDLE/DONE + start=1: SHALL latch mat into an internal buffer, clear valid and err, set busy, zero the issue and write counters, go to ISSUE.
REQ-015 ISSUE: SHALL present one element u per cycle, row-major (index = i*SIZE_B + j), with data = mul_double(mul_double(u,u), -0.5).
REQ-016 ISSUE: SHALL push u and a tag-valid bit into an EXP_LATENCY-deep delay line each cycle.
REQ-017 When the issue counter reaches N = SIZE_A*SIZE_B, SHALL go to DRAIN and push tag-valid=0 from then on.
REQ-018 On each cycle a tag-valid bit exits the delay line, SHALL write mul_double(u_delayed, result) into mat_out at the write counter, then increment that counter.
REQ-019 Write order SHALL equal issue order; no element is skipped or duplicated.
REQ-020 When the write counter reaches N, SHALL go to DONE, set valid=1 and busy=0.
REQ-021 valid SHALL rise exactly N+EXP_LATENCY+1 clock edges after the start edge.
REQ-022 DONE: SHALL hold valid and mat_out until the next accepted start.
REQ-023 start while busy=1 SHALL be ignored: no relatch, no counter change.
REQ-024 Changes to mat after the start edge SHALL NOT affect the run.
REQ-025 underflow and zero flags SHALL NOT set err; the result is used as delivered.
REQ-026 Counters SHALL be $clog2(N+1) bits wide. They SHALL never wrap within a run.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, valid=0, busy=0, err=0, all counters 0, all delay-line tag-valid bits 0, and every mat_out element to +0.0.
REQ-028 Reset asserted mid-run SHALL abort the run; the first start after release SHALL run normally.
REQ-029 Results still in flight in the exp core SHALL be discarded.

Verification
REQ-030 SIZE_A=SIZE_B=2, all elements +0.0, start pulse -> mat_out all +0.0, valid rises exactly 5+EXP_LATENCY edges after start, err=0.
REQ-031 Elements {1.0, -1.0, 2.0, -2.0} -> mat_out {0.6065306597, -0.6065306597, 0.2706705664, -0.2706705664} within 1 ulp, in row-major order.
REQ-032 One element NaN, others 1.0 -> err=1 and valid=1 at normal latency; the other elements = 0.6065306597.
REQ-033 Second start pulse at cycle 2 of a run with changed mat -> ignored; results and timing match the first matrix.
REQ-034 rst_n low at cycle 3 of a run, then a new start -> outputs zero during reset; the new run completes with correct values and exact latency.
REQ-035 Two back-to-back runs (start in DONE) -> valid drops on the start edge, then rises again after N+EXP_LATENCY+1 edges.
